// File: rtl/pipe_stage_hs_pkg.sv
// Shared pipeline definitions: occupancy encodings, skid mode selectors,
// the stage state type and the payload widths of the per-stage bundles.
package pipe_stage_hs_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam bit SKID_OFF = 1'b0;
    localparam bit SKID_ON  = 1'b1;

    // Encoding matches the occupancy value so the two can be compared directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    // Per-stage bundle widths (control + data fields concatenated).
    localparam int IF_ID_W  = 32 + 32;
    localparam int ID_EX_W  = 32 + 32 + 32 + 5 + 8;
    localparam int EX_MEM_W = 32 + 32 + 5 + 4;
    localparam int MEM_WB_W = 32 + 32 + 32 + 32 + 2;

    function automatic logic [1:0] occ_of(input stage_state_t s);
        case (s)
            ST_ONE:  return OCC_ONE;
            ST_TWO:  return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_hs_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count increment requests, stopping at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register with optional two-entry skid buffer,
// synchronous flush and a saturating back-pressure cycle counter.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | nothing held
// ST_ONE   | main entry valid
// ST_TWO   | main and skid entries valid (SKID=1 only)
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter bit SKID   = SKID_ON,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_t      state;
    logic [DATA_W-1:0] main_data;
    logic              push;
    logic              pop;

    // Flush masks both handshakes in the same cycle it is raised.
    assign out_valid = (state != ST_EMPTY) && !flush;
    assign out_data  = main_data;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = occ_of(state);

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_data;
            logic              rdy_q;

            // rdy_q tracks "not full" as a flop so in_ready has no path from out_ready.
            assign in_ready = rdy_q && !flush;

            // Two-entry FSM: the skid slot absorbs the beat accepted while the head stalls.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state     <= ST_EMPTY;
                    rdy_q     <= 1'b1;
                    main_data <= '0;
                    skid_data <= '0;
                end else if (flush) begin
                    state <= ST_EMPTY;
                    rdy_q <= 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (push) begin
                                main_data <= in_data;
                                state     <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (push && pop) begin
                                main_data <= in_data;
                            end else if (push) begin
                                skid_data <= in_data;
                                state     <= ST_TWO;
                                rdy_q     <= 1'b0;
                            end else if (pop) begin
                                state <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (pop) begin
                                main_data <= skid_data;
                                state     <= ST_ONE;
                                rdy_q     <= 1'b1;
                            end
                        end
                        default: begin
                            state <= ST_EMPTY;
                            rdy_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            // Accept when empty, or when the held beat leaves this same cycle.
            assign in_ready = !flush && ((state == ST_EMPTY) || out_ready);

            // Single register: a push always replaces the head, a lone pop empties it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state     <= ST_EMPTY;
                    main_data <= '0;
                end else if (flush) begin
                    state <= ST_EMPTY;
                end else if (push) begin
                    main_data <= in_data;
                    state     <= ST_ONE;
                end else if (pop) begin
                    state <= ST_EMPTY;
                end
            end
        end
    endgenerate

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances (SKID=1, SKID=0, SKID=1 with a
// 4-bit stall counter) share one stimulus stream; a FIFO-level model per
// instance predicts every output on every falling edge.
module tb_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        ir_s1, ov_s1, ir_s0, ov_s0, ir_st, ov_st;
    logic [31:0] od_s1, od_s0, od_st;
    logic [1:0]  oc_s1, oc_s0, oc_st;
    logic [15:0] sc_s1, sc_s0;
    logic [3:0]  sc_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(32), .SKID(1'b1), .CNT_W(16)) dut_s1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_s1), .in_data(in_data),
        .out_valid(ov_s1), .out_ready(out_ready), .out_data(od_s1),
        .occupancy(oc_s1), .stall_cnt(sc_s1));

    pipe_stage_hs #(.DATA_W(32), .SKID(1'b0), .CNT_W(16)) dut_s0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_s0), .in_data(in_data),
        .out_valid(ov_s0), .out_ready(out_ready), .out_data(od_s0),
        .occupancy(oc_s0), .stall_cnt(sc_s0));

    pipe_stage_hs #(.DATA_W(32), .SKID(1'b1), .CNT_W(4)) dut_st (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir_st), .in_data(in_data),
        .out_valid(ov_st), .out_ready(out_ready), .out_data(od_st),
        .occupancy(oc_st), .stall_cnt(sc_st));

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: per instance an ordered list of held beats (max 2) and a stall count.
    logic [31:0] mdl [3][2];
    int          mcnt [3] = '{0, 0, 0};
    int          mstall [3] = '{0, 0, 0};
    int          nout [3] = '{0, 0, 0};
    int          cap [3] = '{2, 1, 2};
    int          smax [3] = '{65535, 65535, 15};

    // Compare every output against the model, then advance the model by one edge.
    always @(negedge clk) begin
        logic        a_ir [3];
        logic        a_ov [3];
        logic [31:0] a_od [3];
        logic [1:0]  a_oc [3];
        int          a_sc [3];
        logic        e_ir, e_ov, do_pop, do_push;
        a_ir = '{ir_s1, ir_s0, ir_st};
        a_ov = '{ov_s1, ov_s0, ov_st};
        a_od = '{od_s1, od_s0, od_st};
        a_oc = '{oc_s1, oc_s0, oc_st};
        a_sc = '{int'(sc_s1), int'(sc_s0), int'(sc_st)};
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                mcnt[k]   = 0;
                mstall[k] = 0;
            end
            e_ov = !flush && (mcnt[k] > 0);
            e_ir = !flush && ((cap[k] == 2) ? (mcnt[k] < 2) : ((mcnt[k] == 0) || out_ready));
            chk("in_ready", k, 32'(a_ir[k]), 32'(e_ir));
            chk("out_valid", k, 32'(a_ov[k]), 32'(e_ov));
            chk("occupancy", k, 32'(a_oc[k]), 32'(mcnt[k]));
            chk("occ_bound", k, 32'(a_oc[k] <= 2'(cap[k])), 32'd1);
            chk("stall_cnt", k, a_sc[k], mstall[k]);
            if (e_ov) chk("out_data", k, a_od[k], mdl[k][0]);
            if (a_ov[k] && out_ready) nout[k]++;
            if (!reset) begin
                if (flush) begin
                    mcnt[k] = 0;
                end else begin
                    do_pop  = e_ov && out_ready;
                    do_push = in_valid && e_ir;
                    if (e_ov && !out_ready && mstall[k] < smax[k]) mstall[k]++;
                    if (do_pop) begin
                        mdl[k][0] = mdl[k][1];
                        mcnt[k]--;
                    end
                    if (do_push) begin
                        mdl[k][mcnt[k]] = in_data;
                        mcnt[k]++;
                    end
                end
            end
        end
    end

    initial begin
        int b0, b1;

        // 1: reset with two beats held, then first beat after release
        cyc(); cyc();
        reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; cyc();
        in_data = 32'h22; cyc();
        in_valid = 1'b0;
        #1;
        chk("pre_reset_occ", 1, 32'(oc_s1), 32'd2);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 1, 32'(ov_s1), 32'd0);
        chk("rst_occ", 1, 32'(oc_s1), 32'd0);
        chk("rst_stall", 1, 32'(sc_s1), 32'd0);
        chk("rst_data", 1, od_s1, 32'd0);
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("ready_after_rst", 1, 32'(ir_s1), 32'd1);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; cyc();
        in_valid = 1'b0;
        #1;
        chk("first_valid", 1, 32'(ov_s1), 32'd1);
        chk("first_data", 1, od_s1, 32'hDEADBEEF);
        cyc();

        // 2: full-rate streaming in both modes
        b0 = nout[0]; b1 = nout[1];
        for (int i = 1; i <= 64; i++) begin
            in_valid = 1'b1; in_data = 32'(i); cyc();
        end
        in_valid = 1'b0;
        cyc(); cyc();
        chk("beats_out", 1, 32'(nout[1] - b1), 32'd64);
        chk("beats_out", 0, 32'(nout[0] - b0), 32'd64);
        chk("stream_stall", 1, 32'(sc_s1), 32'd0);
        chk("stream_stall", 0, 32'(sc_s0), 32'd0);

        // 3: back-pressure fills the skid entry
        reset = 1'b1; cyc(); reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; cyc();
        in_data = 32'hB; cyc();
        in_data = 32'hC; cyc(); cyc();
        #1;
        chk("bp_occ", 1, 32'(oc_s1), 32'd2);
        chk("bp_in_ready", 1, 32'(ir_s1), 32'd0);
        chk("bp_stall", 1, 32'(sc_s1), 32'd3);
        chk("bp_head", 1, od_s1, 32'hA);
        out_ready = 1'b1;
        cyc();
        #1 chk("bp_second", 1, od_s1, 32'hB);
        cyc();
        in_valid = 1'b0;
        #1 chk("bp_third", 1, od_s1, 32'hC);
        chk("bp_stall_after", 1, 32'(sc_s1), 32'd3);
        cyc(); cyc();

        // 4: flush while full with a beat offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; cyc();
        in_data = 32'h2; cyc();
        in_data = 32'h55; flush = 1'b1;
        #1;
        chk("flush_out_valid", 1, 32'(ov_s1), 32'd0);
        chk("flush_in_ready", 1, 32'(ir_s1), 32'd0);
        chk("flush_in_ready", 0, 32'(ir_s0), 32'd0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_flush_occ", 1, 32'(oc_s1), 32'd0);
        chk("post_flush_valid", 1, 32'(ov_s1), 32'd0);
        out_ready = 1'b1;
        repeat (3) cyc();

        // 5: stall counter saturation at 4 bits
        reset = 1'b1; cyc(); reset = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h77; cyc();
        in_valid = 1'b0;
        repeat (20) cyc();
        #1;
        chk("sat_stall", 2, 32'(sc_st), 32'd15);
        chk("wide_stall", 1, 32'(sc_s1), 32'd20);
        repeat (3) cyc();
        chk("sat_hold", 2, 32'(sc_st), 32'd15);
        out_ready = 1'b1;
        cyc(); cyc();

        // 6: random traffic with occasional flush
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = (n % 512 < 128) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
Generic handshaked pipeline-stage register, the parametrised successor to the fixed per-stage bundles (IF/ID … MEM/WB).
- Carries one opaque DATA_W-bit payload (the stage's concatenated control and data fields) with valid/ready flow control, synchronous flush and a stall-cycle counter.
- SKID=1 adds a second entry so in_ready is fully registered and full throughput is kept under back-pressure.
- Sits between any two pipeline stages of the core.

Parameters:
DATA_W, 32, payload width in bits (≥1)
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (in_ready combinational from out_ready)
CNT_W, 16, stall counter width (≥1)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held and incoming beats
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  payload available downstream
out_ready  in  1  downstream accepts
out_data  out  DATA_W  downstream payload (head entry)
occupancy  out  2  number of valid entries held (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  saturating count of back-pressured cycles

Behaviour:
- Handshake:
  - Beat accepted on a rising edge when in_valid && in_ready.
  - Beat delivered when out_valid && out_ready.
  - Order strictly FIFO; no beat duplicated or dropped except by flush.
- Reset (async, asserting reset): all valid bits 0, occupancy 0, stall_cnt 0, data registers 0. out_valid=0 immediately. in_ready=1 on the first cycle after reset deassertion.
- Data registers load only on an accepted beat. With no load, they hold; out_data is stable while out_valid && !out_ready.
- Latency: accepted beat visible on out_valid/out_data the following cycle. No combinational in→out data path.
- SKID=1, states EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main+skid valid):
  - in_ready = (state != TWO), registered.
  - EMPTY: push → ONE.
  - ONE: push & pop → ONE (main ← in_data). Push only → TWO (skid ← in_data). Pop only → EMPTY.
  - TWO: pop → ONE (main ← skid). Push impossible (in_ready=0).
  - Sustained in_valid=out_ready=1 gives 1 beat/cycle.
- SKID=0:
  - in_ready = !valid || out_ready.
  - Push & pop in the same cycle replaces the entry; full throughput.
  - occupancy is 0 or 1.
- Flush (priority over everything except reset):
  - While flush=1, out_valid=0 and in_ready=0, both combinationally, so no handshake completes.
  - Next edge: all valid bits cleared, state EMPTY; data registers keep their values.
  - Flush held several cycles keeps the stage empty.
- stall_cnt:
  - Increments by 1 on each edge where out_valid && !out_ready and flush=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Reset mid-operation: any held beats are lost; no partial beat is ever emitted.
- DATA_W=1 and CNT_W=1 are legal.

Decomposition:
- Shared pipeline package: occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2) and the SKID mode constants. Per-stage payload widths as localparams derived from field widths (e.g. MEM/WB bundle = 32+32+32+32+2 = 130).
- One natural sub-module: sat_counter (parametrised CNT_W, inc input, saturating), reused for other performance counters.
- Stage wrappers instantiate pipe_stage_hs with packed field concatenation.

Test Plan:
1. Reset/basic, SKID=1, DATA_W=32: assert reset mid-stream with occ=2 → out_valid=0, occupancy=0, stall_cnt=0, data registers 0 immediately. After release, push 0xDEADBEEF → out_data=0xDEADBEEF, out_valid=1 next cycle.
2. Throughput: stream 0x1..0x40 with out_ready=1 → 64 beats out in order, one per cycle after 1-cycle latency, stall_cnt=0. Repeat with SKID=0 → same result.
3. Back-pressure, SKID=1:
   - Push 0xA, 0xB, 0xC with out_ready=0 → occupancy=2 after 0xB, in_ready=0, 0xC held upstream.
   - out_ready=1 → outputs 0xA, 0xB, 0xC in order.
   - stall_cnt equals the number of cycles with out_valid && !out_ready.
4. Flush with occ=2 and in_valid=1 (0x55) in the same cycle → out_valid=0 and in_ready=0 that cycle. Next cycle occupancy=0 and 0x55 is never output.
5. Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays 15.
6. Random valid/ready (10k cycles, both modes) against a scoreboard FIFO → no loss/duplication/reorder. occupancy never exceeds 2 (SKID=1) or 1 (SKID=0).
